mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter OPC_W, default 4, opcode field width.
REQ-002 SHALL have parameter FUNC_W, default 4, function field width.
REQ-003 SHALL have parameter RET_W, default 16, retire-counter width.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, maximum wait cycles for any memory request before trapping.
REQ-005 SHALL have ports:
- clk  in  1  clock; one clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-low.
- opcode  in  OPC_W  IR opcode field.
- func_field  in  FUNC_W  IR function field.
- mem_ready  in  1  memory has completed the current request.
- halt_req  in  1  request to stop at the next instruction boundary.
- trap_clr  in  1  leave TRAP.
- pc_src  out  2  PC source select.
- alu_op  out  3  ALU operation.
- alu_src_a  out  1  ALU A select.
- alu_src_b  out  3  ALU B select.
- sign_extend  out  1  immediate extension mode.
- read_r1  out  2  read-register-1 select.
- read_r2  out  1  read-register-2 select.
- reg_write_dst, mem_to_reg, pc_beq_cond, pc_bnq_cond, pc_write, mem_write, mem_read, ir_write, reg_write  out  1 each  datapath strobes.
- halted  out  1  in HALT.
- trap  out  1  in TRAP.
- trap_cause  out  2  01 illegal function, 10 memory timeout.
- retire_cnt  out  RET_W  retired-instruction count.

Function
REQ-006 SHALL implement states FETCH, HALT, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_LOAD, TRAP; every output not asserted in a state SHALL be 0 (no X).
REQ-007 FETCH with halt_req=1 SHALL assert nothing and go to HALT; HALT SHALL assert halted and return to FETCH the cycle after halt_req=0.
REQ-008 FETCH with halt_req=0 SHALL hold mem_read=1, alu_src_a=0, alu_src_b=001, alu_op=000; in the cycle mem_ready=1 it SHALL also assert ir_write and pc_write and go to DECODE.
REQ-009 DECODE SHALL register opcode and func_field into op_q/func_q; EXEC and later states SHALL use only op_q/func_q.
REQ-010 DECODE SHALL go to TRAP with trap_cause=01 for opcode 0000 with func not in {0001,0010,0011}; otherwise it SHALL go to EXEC.
REQ-011 EXEC SHALL drive these alu_op/alu_src_b/read_r1/sign_extend values per op, all with alu_src_a=1:
- ADD 000/000/00
- ADDI1 000/010/01/1
- ADDI2 000/010/01/0
- SUB 001/000/00
- SUBI1 001/010/01/1
- SUBI2 001/010/01/0
- NAND 010/000/00
- NANDI 010/010/01/0
- OR 101/000/00
- ORI 101/010/01/1
- SLL 011/101/01
- SRL 100/101/01
- SRA 111/101/01
- LW/SW 000/011/10/1 with read_r2=1.
REQ-012 EXEC for BEQ/BNQ SHALL drive pc_src=10, alu_op=001, alu_src_b=000 and pc_beq_cond or pc_bnq_cond respectively. EXEC for JMP SHALL drive pc_write=1, alu_src_a=0, alu_src_b=100. All three SHALL then go to FETCH.
REQ-013 From EXEC, ALU ops SHALL go to WB_ALU, LW to MEM_RD and SW to MEM_WR.
REQ-014 MEM_RD SHALL hold mem_read=1 until mem_ready, then go to WB_LOAD. MEM_WR SHALL hold mem_write=1 and read_r2=1 until mem_ready, then go to FETCH.
REQ-015 WB_ALU SHALL assert reg_write and reg_write_dst with mem_to_reg=0; WB_LOAD SHALL assert reg_write, reg_write_dst and mem_to_reg=1. Both SHALL then go to FETCH.
REQ-016 A wait counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR and count cycles with mem_ready=0. When it equals MEM_TIMEOUT with mem_ready=0, the FSM SHALL go to TRAP with trap_cause=10 and drop the strobe.
REQ-017 mem_ready in the timeout cycle SHALL win: the request completes normally.
REQ-018 TRAP SHALL assert trap and hold trap_cause; trap_clr=1 SHALL go to FETCH and clear trap_cause. halt_req SHALL be ignored in TRAP.
REQ-019 retire_cnt SHALL increment by 1 on each transition into FETCH from EXEC, MEM_WR, WB_ALU or WB_LOAD, saturating at all-ones.

Reset
REQ-020 rst=0 at a clock edge SHALL force FETCH, wait counter 0, retire_cnt 0, trap_cause 00, op_q/func_q 0, all outputs 0, regardless of state (including mid memory wait).

Structure
REQ-021 State encoding, opcode/func constants, ALU-op and ALU-src-B codes and trap causes SHALL live in shared package mc_ctrl_pkg.
REQ-022 The EXEC control table SHALL be a combinational sub-module mc_exec_decode (op_q, func_q -> EXEC control word).

Verification
REQ-023 ADD with mem_ready=1 every cycle -> FETCH, DECODE, EXEC, WB_ALU, FETCH; reg_write in cycle 4; retire_cnt=1.
REQ-024 LW with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles; WB_LOAD with mem_to_reg=1; retire_cnt increments once.
REQ-025 Opcode 0000, func 0101 -> TRAP, trap_cause=01; trap_clr pulse -> FETCH next cycle; retire_cnt unchanged.
REQ-026 MEM_TIMEOUT=15, mem_ready=0 in FETCH -> TRAP, trap_cause=10, after 16 FETCH cycles. Repeat with mem_ready=1 on the 16th cycle -> DECODE.
REQ-027 halt_req=1 at FETCH -> halted until released; rst=0 asserted during a MEM_WR wait -> all outputs 0 next cycle, FETCH; retire_cnt=2^RET_W-1 plus one retire -> stays saturated.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes,
// ALU/B-source codes, trap causes and the EXEC control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_HALT,
        S_DECODE,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_LOAD,
        S_TRAP
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI1 = 4'h1;
    localparam logic [3:0] OP_ADDI2 = 4'h2;
    localparam logic [3:0] OP_SUBI1 = 4'h3;
    localparam logic [3:0] OP_SUBI2 = 4'h4;
    localparam logic [3:0] OP_NANDI = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_ORI   = 4'h7;
    localparam logic [3:0] OP_SLL   = 4'h8;
    localparam logic [3:0] OP_SRL   = 4'h9;
    localparam logic [3:0] OP_SRA   = 4'hA;
    localparam logic [3:0] OP_LW    = 4'hB;
    localparam logic [3:0] OP_SW    = 4'hC;
    localparam logic [3:0] OP_BEQ   = 4'hD;
    localparam logic [3:0] OP_BNQ   = 4'hE;
    localparam logic [3:0] OP_JMP   = 4'hF;

    localparam logic [3:0] FN_ADD  = 4'h1;
    localparam logic [3:0] FN_SUB  = 4'h2;
    localparam logic [3:0] FN_NAND = 4'h3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_SRA  = 3'b111;

    localparam logic [2:0] SRCB_REG   = 3'b000;
    localparam logic [2:0] SRCB_FOUR  = 3'b001;
    localparam logic [2:0] SRCB_IMM   = 3'b010;
    localparam logic [2:0] SRCB_OFF   = 3'b011;
    localparam logic [2:0] SRCB_JMP   = 3'b100;
    localparam logic [2:0] SRCB_SHAMT = 3'b101;

    localparam logic [1:0] R1_RS  = 2'b00;
    localparam logic [1:0] R1_RD  = 2'b01;
    localparam logic [1:0] R1_BAS = 2'b10;

    localparam logic [1:0] PC_BR = 2'b10;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_TMO  = 2'b10;

    typedef enum logic [1:0] {
        K_ALU,
        K_LOAD,
        K_STORE,
        K_FLOW
    } kind_t;

    typedef struct packed {
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic       sign_extend;
        logic [1:0] read_r1;
        logic       read_r2;
        logic       pc_beq_cond;
        logic       pc_bnq_cond;
        logic       pc_write;
        kind_t      kind;
    } exec_ctrl_t;

    function automatic exec_ctrl_t alu_word(
        input logic [2:0] op,
        input logic [2:0] srcb,
        input logic [1:0] r1,
        input logic       sx
    );
        exec_ctrl_t w;
        w             = '0;
        w.alu_op      = op;
        w.alu_src_a   = 1'b1;
        w.alu_src_b   = srcb;
        w.read_r1     = r1;
        w.sign_extend = sx;
        w.kind        = K_ALU;
        return w;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit bundle: instruction fields and memory/halt/trap handshakes
// in, datapath control strobes and status out.
interface mc_control_unit_if #(
    parameter int OPC_W  = 4,
    parameter int FUNC_W = 4,
    parameter int RET_W  = 16
);
    logic [OPC_W-1:0]  opcode;
    logic [FUNC_W-1:0] func_field;
    logic              mem_ready;
    logic              halt_req;
    logic              trap_clr;

    logic [1:0]        pc_src;
    logic [2:0]        alu_op;
    logic              alu_src_a;
    logic [2:0]        alu_src_b;
    logic              sign_extend;
    logic [1:0]        read_r1;
    logic              read_r2;
    logic              reg_write_dst;
    logic              mem_to_reg;
    logic              pc_beq_cond;
    logic              pc_bnq_cond;
    logic              pc_write;
    logic              mem_write;
    logic              mem_read;
    logic              ir_write;
    logic              reg_write;
    logic              halted;
    logic              trap;
    logic [1:0]        trap_cause;
    logic [RET_W-1:0]  retire_cnt;

    modport master (
        input  opcode, func_field, mem_ready, halt_req, trap_clr,
        output pc_src, alu_op, alu_src_a, alu_src_b, sign_extend,
        output read_r1, read_r2, reg_write_dst, mem_to_reg,
        output pc_beq_cond, pc_bnq_cond, pc_write, mem_write,
        output mem_read, ir_write, reg_write, halted, trap,
        output trap_cause, retire_cnt
    );

    modport slave (
        output opcode, func_field, mem_ready, halt_req, trap_clr,
        input  pc_src, alu_op, alu_src_a, alu_src_b, sign_extend,
        input  read_r1, read_r2, reg_write_dst, mem_to_reg,
        input  pc_beq_cond, pc_bnq_cond, pc_write, mem_write,
        input  mem_read, ir_write, reg_write, halted, trap,
        input  trap_cause, retire_cnt
    );
endinterface

// File: rtl/mc_exec_decode.sv
// EXEC-state control table: latched opcode/function -> control word
// plus the class that picks the post-EXEC state.
module mc_exec_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int FUNC_W = 4
) (
    input  logic [OPC_W-1:0]  i_op_q,
    input  logic [FUNC_W-1:0] i_func_q,
    output exec_ctrl_t        o_ctrl
);
    logic w_rt;
    assign w_rt = (i_op_q == OPC_W'(OP_RTYPE));

    always_comb begin
        o_ctrl = '0;
        unique case (1'b1)
            w_rt && (i_func_q == FUNC_W'(FN_ADD)):
                o_ctrl = alu_word(ALU_ADD, SRCB_REG, R1_RS, 1'b0);
            w_rt && (i_func_q == FUNC_W'(FN_SUB)):
                o_ctrl = alu_word(ALU_SUB, SRCB_REG, R1_RS, 1'b0);
            w_rt && (i_func_q == FUNC_W'(FN_NAND)):
                o_ctrl = alu_word(ALU_NAND, SRCB_REG, R1_RS, 1'b0);
            i_op_q == OPC_W'(OP_ADDI1):
                o_ctrl = alu_word(ALU_ADD, SRCB_IMM, R1_RD, 1'b1);
            i_op_q == OPC_W'(OP_ADDI2):
                o_ctrl = alu_word(ALU_ADD, SRCB_IMM, R1_RD, 1'b0);
            i_op_q == OPC_W'(OP_SUBI1):
                o_ctrl = alu_word(ALU_SUB, SRCB_IMM, R1_RD, 1'b1);
            i_op_q == OPC_W'(OP_SUBI2):
                o_ctrl = alu_word(ALU_SUB, SRCB_IMM, R1_RD, 1'b0);
            i_op_q == OPC_W'(OP_NANDI):
                o_ctrl = alu_word(ALU_NAND, SRCB_IMM, R1_RD, 1'b0);
            i_op_q == OPC_W'(OP_OR):
                o_ctrl = alu_word(ALU_OR, SRCB_REG, R1_RS, 1'b0);
            i_op_q == OPC_W'(OP_ORI):
                o_ctrl = alu_word(ALU_OR, SRCB_IMM, R1_RD, 1'b1);
            i_op_q == OPC_W'(OP_SLL):
                o_ctrl = alu_word(ALU_SLL, SRCB_SHAMT, R1_RD, 1'b0);
            i_op_q == OPC_W'(OP_SRL):
                o_ctrl = alu_word(ALU_SRL, SRCB_SHAMT, R1_RD, 1'b0);
            i_op_q == OPC_W'(OP_SRA):
                o_ctrl = alu_word(ALU_SRA, SRCB_SHAMT, R1_RD, 1'b0);
            i_op_q == OPC_W'(OP_LW): begin
                o_ctrl         = alu_word(ALU_ADD, SRCB_OFF, R1_BAS, 1'b1);
                o_ctrl.read_r2 = 1'b1;
                o_ctrl.kind    = K_LOAD;
            end
            i_op_q == OPC_W'(OP_SW): begin
                o_ctrl         = alu_word(ALU_ADD, SRCB_OFF, R1_BAS, 1'b1);
                o_ctrl.read_r2 = 1'b1;
                o_ctrl.kind    = K_STORE;
            end
            i_op_q == OPC_W'(OP_BEQ): begin
                o_ctrl.pc_src      = PC_BR;
                o_ctrl.alu_op      = ALU_SUB;
                o_ctrl.pc_beq_cond = 1'b1;
                o_ctrl.kind        = K_FLOW;
            end
            i_op_q == OPC_W'(OP_BNQ): begin
                o_ctrl.pc_src      = PC_BR;
                o_ctrl.alu_op      = ALU_SUB;
                o_ctrl.pc_bnq_cond = 1'b1;
                o_ctrl.kind        = K_FLOW;
            end
            i_op_q == OPC_W'(OP_JMP): begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_JMP;
                o_ctrl.kind      = K_FLOW;
            end
            default: o_ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM with memory-wait timeout, halt, trap and a
// saturating retired-instruction counter.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W       = 4,
    parameter int FUNC_W      = 4,
    parameter int RET_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst,
    mc_control_unit_if.master bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_wait;
    logic [RET_W-1:0]  r_retire;
    logic [1:0]        r_cause;
    logic [OPC_W-1:0]  r_op_q;
    logic [FUNC_W-1:0] r_func_q;
    exec_ctrl_t        w_ex;
    logic              w_tmo;
    logic              w_illegal;
    logic              w_retire;

    mc_exec_decode #(
        .OPC_W  (OPC_W),
        .FUNC_W (FUNC_W)
    ) u_dec (
        .i_op_q   (r_op_q),
        .i_func_q (r_func_q),
        .o_ctrl   (w_ex)
    );

    // mem_ready in the limit cycle wins over the timeout
    assign w_tmo = (r_wait == CNT_W'(MEM_TIMEOUT)) && !bus.mem_ready;

    assign w_illegal = (bus.opcode == OPC_W'(OP_RTYPE))
        && (bus.func_field != FUNC_W'(FN_ADD))
        && (bus.func_field != FUNC_W'(FN_SUB))
        && (bus.func_field != FUNC_W'(FN_NAND));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.halt_req)       w_next = S_HALT;
                else if (bus.mem_ready) w_next = S_DECODE;
                else if (w_tmo)         w_next = S_TRAP;
            end
            S_HALT:   if (!bus.halt_req) w_next = S_FETCH;
            S_DECODE: w_next = w_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (w_ex.kind)
                    K_ALU:   w_next = S_WB_ALU;
                    K_LOAD:  w_next = S_MEM_RD;
                    K_STORE: w_next = S_MEM_WR;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM_RD: begin
                if (bus.mem_ready) w_next = S_WB_LOAD;
                else if (w_tmo)    w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) w_next = S_FETCH;
                else if (w_tmo)    w_next = S_TRAP;
            end
            S_WB_ALU, S_WB_LOAD: w_next = S_FETCH;
            S_TRAP:   if (bus.trap_clr) w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    assign w_retire = (w_next == S_FETCH) && (r_state inside
        {S_EXEC, S_MEM_WR, S_WB_ALU, S_WB_LOAD});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_FETCH;
            r_wait   <= '0;
            r_retire <= '0;
            r_cause  <= CAUSE_NONE;
            r_op_q   <= '0;
            r_func_q <= '0;
        end else begin
            r_state <= w_next;
            // any state change restarts the wait count
            if (w_next != r_state)
                r_wait <= '0;
            else if (!bus.mem_ready && r_wait != CNT_W'(MEM_TIMEOUT))
                r_wait <= r_wait + 1'b1;
            if (r_state == S_DECODE) begin
                r_op_q   <= bus.opcode;
                r_func_q <= bus.func_field;
            end
            if (w_next == S_TRAP && r_state != S_TRAP)
                r_cause <= (r_state == S_DECODE) ? CAUSE_ILL : CAUSE_TMO;
            else if (r_state == S_TRAP && bus.trap_clr)
                r_cause <= CAUSE_NONE;
            if (w_retire && r_retire != '1)
                r_retire <= r_retire + 1'b1;
        end
    end

    always_comb begin
        bus.pc_src        = '0;
        bus.alu_op        = '0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = '0;
        bus.sign_extend   = 1'b0;
        bus.read_r1       = '0;
        bus.read_r2       = 1'b0;
        bus.reg_write_dst = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.pc_beq_cond   = 1'b0;
        bus.pc_bnq_cond   = 1'b0;
        bus.pc_write      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_read      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.halted        = 1'b0;
        bus.trap          = 1'b0;
        bus.trap_cause    = rst ? r_cause : CAUSE_NONE;
        bus.retire_cnt    = rst ? r_retire : '0;
        if (rst) begin
            case (r_state)
                S_FETCH: begin
                    if (!bus.halt_req) begin
                        bus.mem_read  = 1'b1;
                        bus.alu_src_b = SRCB_FOUR;
                        bus.ir_write  = bus.mem_ready;
                        bus.pc_write  = bus.mem_ready;
                    end
                end
                S_HALT: bus.halted = 1'b1;
                S_EXEC: begin
                    bus.pc_src      = w_ex.pc_src;
                    bus.alu_op      = w_ex.alu_op;
                    bus.alu_src_a   = w_ex.alu_src_a;
                    bus.alu_src_b   = w_ex.alu_src_b;
                    bus.sign_extend = w_ex.sign_extend;
                    bus.read_r1     = w_ex.read_r1;
                    bus.read_r2     = w_ex.read_r2;
                    bus.pc_beq_cond = w_ex.pc_beq_cond;
                    bus.pc_bnq_cond = w_ex.pc_bnq_cond;
                    bus.pc_write    = w_ex.pc_write;
                end
                S_MEM_RD: bus.mem_read = 1'b1;
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.read_r2   = 1'b1;
                end
                S_WB_ALU: begin
                    bus.reg_write     = 1'b1;
                    bus.reg_write_dst = 1'b1;
                end
                S_WB_LOAD: begin
                    bus.reg_write     = 1'b1;
                    bus.reg_write_dst = 1'b1;
                    bus.mem_to_reg    = 1'b1;
                end
                S_TRAP:  bus.trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized scoreboard bench: per-instruction cycle sequences are
// expanded into expected output records and checked at each negedge.
module tb_mc_control_unit;

    localparam int TMO  = 15;
    localparam int RMAX = 15;

    typedef struct packed {
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       src_a;
        logic [2:0] src_b;
        logic       sx;
        logic [1:0] r1;
        logic       r2;
        logic       dst;
        logic       m2r;
        logic       beq;
        logic       bnq;
        logic       pcw;
        logic       mw;
        logic       mr;
        logic       irw;
        logic       rw;
        logic       halted;
        logic       trap;
        logic [1:0] cause;
        logic [3:0] ret;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ret_m  = 0;

    mc_control_unit_if #(.OPC_W(4), .FUNC_W(4), .RET_W(4)) bus ();

    mc_control_unit #(
        .OPC_W       (4),
        .FUNC_W      (4),
        .RET_W       (4),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    function automatic obs_t sample();
        obs_t g;
        g.pc_src = bus.pc_src;
        g.alu_op = bus.alu_op;
        g.src_a  = bus.alu_src_a;
        g.src_b  = bus.alu_src_b;
        g.sx     = bus.sign_extend;
        g.r1     = bus.read_r1;
        g.r2     = bus.read_r2;
        g.dst    = bus.reg_write_dst;
        g.m2r    = bus.mem_to_reg;
        g.beq    = bus.pc_beq_cond;
        g.bnq    = bus.pc_bnq_cond;
        g.pcw    = bus.pc_write;
        g.mw     = bus.mem_write;
        g.mr     = bus.mem_read;
        g.irw    = bus.ir_write;
        g.rw     = bus.reg_write;
        g.halted = bus.halted;
        g.trap   = bus.trap;
        g.cause  = bus.trap_cause;
        g.ret    = bus.retire_cnt;
        return g;
    endfunction

    // monitor: one record per cycle, compared away from the clock edge
    initial begin
        rec_t r;
        obs_t g;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                g = sample();
                checks++;
                if (g !== r.v) begin
                    errors++;
                    $display("FAIL %s t=%0t got=%h exp=%h",
                             r.tag, $time, g, r.v);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic mr, input logic hr,
                       input logic tc, input logic [3:0] op,
                       input logic [3:0] fn, input obs_t e,
                       input string tag);
        rec_t rr;
        rst            = r;
        bus.mem_ready  = mr;
        bus.halt_req   = hr;
        bus.trap_clr   = tc;
        bus.opcode     = op;
        bus.func_field = fn;
        if (r) e.ret = 4'(ret_m);
        else   e = '0;
        rr.v   = e;
        rr.tag = tag;
        q.push_back(rr);
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        if (ret_m < RMAX) ret_m++;
    endtask

    task automatic reset_seq(input int n);
        ret_m = 0;
        repeat (n) cyc(1'b0, rb(), rb(), rb(), r4(), r4(), '0, "reset");
    endtask

    task automatic trap_seq(input logic [1:0] cause);
        obs_t e;
        e       = '0;
        e.trap  = 1'b1;
        e.cause = cause;
        repeat ($urandom_range(0, 3))
            cyc(1'b1, rb(), rb(), 1'b0, r4(), r4(), e, "trap_hold");
        cyc(1'b1, rb(), rb(), 1'b1, r4(), r4(), e, "trap_clr");
    endtask

    task automatic halt_seq(input int n);
        obs_t e;
        e = '0;
        cyc(1'b1, rb(), 1'b1, rb(), r4(), r4(), e, "halt_enter");
        e.halted = 1'b1;
        repeat (n) cyc(1'b1, rb(), 1'b1, rb(), r4(), r4(), e, "halted");
        cyc(1'b1, rb(), 1'b0, rb(), r4(), r4(), e, "halt_release");
    endtask

    // d not-ready cycles then ready; d > TMO ends in a timeout trap;
    // abort >= 0 drops rst after that many wait cycles
    task automatic mem_wait(input obs_t base, input int d, input int abort,
                            input bit fetch, output bit ok);
        obs_t e;
        ok = 1'b0;
        for (int k = 0; k <= TMO; k++) begin
            if (k == abort) begin
                reset_seq(2);
                return;
            end
            e = base;
            if (k == d) begin
                if (fetch) begin
                    e.irw = 1'b1;
                    e.pcw = 1'b1;
                end
                cyc(1'b1, 1'b1, 1'b0, rb(), r4(), r4(), e, "mem_done");
                ok = 1'b1;
                return;
            end
            cyc(1'b1, 1'b0, 1'b0, rb(), r4(), r4(), e, "mem_wait");
            if (k == TMO) begin
                trap_seq(2'b10);
                return;
            end
        end
    endtask

    function automatic obs_t aw(input logic [2:0] op, input logic [2:0] b,
                                input logic [1:0] r1, input logic sx);
        obs_t e;
        e        = '0;
        e.src_a  = 1'b1;
        e.alu_op = op;
        e.src_b  = b;
        e.r1     = r1;
        e.sx     = sx;
        return e;
    endfunction

    // kind: 0 ALU, 1 load, 2 store, 3 branch/jump
    function automatic obs_t exec_exp(input logic [3:0] op,
                                      input logic [3:0] fn,
                                      output int kind);
        obs_t e;
        e    = '0;
        kind = 0;
        case (op)
            4'h0: case (fn)
                4'h1:    e = aw(3'b000, 3'b000, 2'b00, 1'b0);
                4'h2:    e = aw(3'b001, 3'b000, 2'b00, 1'b0);
                default: e = aw(3'b010, 3'b000, 2'b00, 1'b0);
            endcase
            4'h1: e = aw(3'b000, 3'b010, 2'b01, 1'b1);
            4'h2: e = aw(3'b000, 3'b010, 2'b01, 1'b0);
            4'h3: e = aw(3'b001, 3'b010, 2'b01, 1'b1);
            4'h4: e = aw(3'b001, 3'b010, 2'b01, 1'b0);
            4'h5: e = aw(3'b010, 3'b010, 2'b01, 1'b0);
            4'h6: e = aw(3'b101, 3'b000, 2'b00, 1'b0);
            4'h7: e = aw(3'b101, 3'b010, 2'b01, 1'b1);
            4'h8: e = aw(3'b011, 3'b101, 2'b01, 1'b0);
            4'h9: e = aw(3'b100, 3'b101, 2'b01, 1'b0);
            4'hA: e = aw(3'b111, 3'b101, 2'b01, 1'b0);
            4'hB, 4'hC: begin
                e    = aw(3'b000, 3'b011, 2'b10, 1'b1);
                e.r2 = 1'b1;
                kind = (op == 4'hB) ? 1 : 2;
            end
            4'hD, 4'hE: begin
                e.pc_src = 2'b10;
                e.alu_op = 3'b001;
                e.beq    = (op == 4'hD);
                e.bnq    = (op == 4'hE);
                kind     = 3;
            end
            default: begin
                e.pcw   = 1'b1;
                e.src_b = 3'b100;
                kind    = 3;
            end
        endcase
        return e;
    endfunction

    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn,
                             input int fd, input int md, input int abort);
        obs_t e;
        bit   ok;
        int   kind;
        e        = '0;
        e.mr     = 1'b1;
        e.src_b  = 3'b001;
        mem_wait(e, fd, -1, 1'b1, ok);
        if (!ok) return;
        cyc(1'b1, rb(), rb(), rb(), op, fn, '0, "decode");
        if (op == 4'h0 && !(fn inside {4'h1, 4'h2, 4'h3})) begin
            trap_seq(2'b01);
            return;
        end
        e = exec_exp(op, fn, kind);
        cyc(1'b1, rb(), rb(), rb(), r4(), r4(), e, "exec");
        case (kind)
            0: begin
                e     = '0;
                e.rw  = 1'b1;
                e.dst = 1'b1;
                cyc(1'b1, rb(), rb(), rb(), r4(), r4(), e, "wb_alu");
                bump();
            end
            1: begin
                e    = '0;
                e.mr = 1'b1;
                mem_wait(e, md, abort, 1'b0, ok);
                if (!ok) return;
                e     = '0;
                e.rw  = 1'b1;
                e.dst = 1'b1;
                e.m2r = 1'b1;
                cyc(1'b1, rb(), rb(), rb(), r4(), r4(), e, "wb_load");
                bump();
            end
            2: begin
                e    = '0;
                e.mw = 1'b1;
                e.r2 = 1'b1;
                mem_wait(e, md, abort, 1'b0, ok);
                if (ok) bump();
            end
            default: bump();
        endcase
    endtask

    function automatic int rdelay();
        int s;
        s = int'($urandom_range(0, 9));
        if (s <= 6) return int'($urandom_range(0, 3));
        if (s == 7) return TMO;
        if (s == 8) return TMO + 1;
        return int'($urandom_range(4, 14));
    endfunction

    initial begin
        logic [3:0] op;
        logic [3:0] fn;
        rst            = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.halt_req   = 1'b0;
        bus.trap_clr   = 1'b0;
        bus.opcode     = '0;
        bus.func_field = '0;
        @(posedge clk);
        #1;
        reset_seq(2);
        run_instr(4'h0, 4'h1, 0, 0, -1);
        run_instr(4'hB, r4(), 0, 3, -1);
        run_instr(4'h0, 4'h5, 0, 0, -1);
        run_instr(4'h1, r4(), TMO + 1, 0, -1);
        run_instr(4'h0, 4'h1, TMO, 0, -1);
        run_instr(4'hC, r4(), 1, TMO + 1, -1);
        run_instr(4'hB, r4(), 0, TMO, -1);
        halt_seq(3);
        run_instr(4'hD, r4(), 0, 0, -1);
        run_instr(4'hF, r4(), 0, 0, -1);
        run_instr(4'hC, r4(), 0, 10, 2);
        for (int i = 0; i < 160; i++) begin
            op = r4();
            fn = r4();
            if (op == 4'h0 && $urandom_range(0, 3) != 0)
                fn = 4'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) halt_seq(int'($urandom_range(0, 2)));
            run_instr(op, fn, rdelay(), rdelay(), -1);
        end
        for (int i = 0; i < 18; i++) run_instr(4'hE, r4(), 0, 0, -1);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
